// File: rtl/conv_window_sequencer_if.sv
// Scratchpad read bus and result stream between the convolution window sequencer
// and its surroundings. The sequencer is the master of both the reads and the result.
interface conv_window_sequencer_if #(
    parameter int ADDR_LEN = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40
);
    logic [ADDR_LEN-1:0]      if_rd_addr;
    logic [ADDR_LEN-1:0]      filt_rd_addr;
    logic                     rd_en;
    logic signed [DATA_W-1:0] if_data;
    logic signed [DATA_W-1:0] filt_data;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output if_rd_addr, filt_rd_addr, rd_en, out_data, out_valid,
        input  if_data, filt_data, out_ready
    );

    modport slave (
        input  if_rd_addr, filt_rd_addr, rd_en, out_data, out_valid,
        output if_data, filt_data, out_ready
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Sliding-window MAC sequencer over a circular input scratchpad and a linear filter scratchpad.
// Optional build macro CONV_RELU_EN clamps negative results to zero on the output.
//
// state  | meaning
// IDLE   | waiting for start
// WAIT   | waiting until the window holds filt_len samples
// READ   | issuing tap reads k = 0..N-1, accumulating tap k-1
// DRAIN  | accumulating the last tap
// OUT    | result presented until out_ready
// FINISH | done pulse, release busy
module conv_window_sequencer #(
    parameter int ADDR_LEN      = 4,
    parameter int SCRATCH_DEPTH = 16,
    parameter int DATA_W        = 16,
    parameter int ACC_W         = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_LEN-1:0] filt_len_i,
    input  logic [7:0]          num_out_i,
    input  logic [ADDR_LEN-1:0] if_wr_ptr_i,
    output logic [ADDR_LEN-1:0] win_start_o,
    output logic                busy_o,
    output logic                done_o,
    conv_window_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [ADDR_LEN:0]   DEPTH   = SCRATCH_DEPTH[ADDR_LEN:0];
    localparam logic [ADDR_LEN-1:0] A_ONE   = {{(ADDR_LEN-1){1'b0}}, 1'b1};
    localparam int                  PROD_W  = 2 * DATA_W;

    logic [2:0]              state_q, state_d;
    logic [ADDR_LEN-1:0]     n_q, n_d;
    logic [ADDR_LEN-1:0]     k_q, k_d;
    logic [ADDR_LEN-1:0]     ws_q, ws_d;
    logic [7:0]              out_left_q, out_left_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [ADDR_LEN:0]       wr_ext, ws_ext, avail, rd_sum, rd_wrap;
    logic [ADDR_LEN-1:0]     ws_next;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] result;

    // Occupancy modulo depth; equal pointers mean empty.
    assign wr_ext  = {1'b0, if_wr_ptr_i};
    assign ws_ext  = {1'b0, ws_q};
    assign avail   = (wr_ext >= ws_ext) ? (wr_ext - ws_ext) : (wr_ext + DEPTH - ws_ext);
    assign rd_sum  = ws_ext + {1'b0, k_q};
    assign rd_wrap = (rd_sum >= DEPTH) ? (rd_sum - DEPTH) : rd_sum;
    assign ws_next = (ws_ext == DEPTH - 1'b1) ? '0 : (ws_q + A_ONE);

    assign prod     = bus.if_data * bus.filt_data;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef CONV_RELU_EN
    assign result = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    assign result = acc_q;
`endif

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        ws_d       = ws_q;
        out_left_d = out_left_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d        = filt_len_i;
                    out_left_d = num_out_i;
                    busy_d     = 1'b1;
                    state_d    = (num_out_i == 8'd0) ? S_FINISH : S_WAIT;
                end
            end
            S_WAIT: begin
                if (n_q == '0) begin
                    acc_d   = '0;
                    state_d = S_OUT;
                end else if (avail >= {1'b0, n_q}) begin
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Data for tap k-1 returns during tap k's read cycle.
                if (k_q != '0) begin
                    acc_d = acc_q + prod_ext;
                end
                if (k_q == n_q - A_ONE) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + A_ONE;
                end
            end
            S_DRAIN: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    ws_d       = ws_next;
                    out_left_d = out_left_q - 8'd1;
                    state_d    = (out_left_q == 8'd1) ? S_FINISH : S_WAIT;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            ws_q       <= '0;
            out_left_q <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            ws_q       <= ws_d;
            out_left_q <= out_left_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_en        = (state_q == S_READ);
    assign bus.if_rd_addr   = bus.rd_en ? rd_wrap[ADDR_LEN-1:0] : '0;
    assign bus.filt_rd_addr = bus.rd_en ? k_q : '0;
    assign bus.out_valid    = (state_q == S_OUT);
    assign bus.out_data     = bus.out_valid ? result : '0;

    assign win_start_o = ws_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: expected reads and results are queued
// at start and compared as the DUT issues reads and completes output handshakes.
module tb_conv_window_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [3:0] filt_len_i;
    logic [7:0] num_out_i;
    logic [3:0] if_wr_ptr_i;
    logic [3:0] win_start_o;
    logic       busy_o;
    logic       done_o;

    conv_window_sequencer_if #(.ADDR_LEN(4), .DATA_W(16), .ACC_W(40)) bus ();

    conv_window_sequencer #(
        .ADDR_LEN(4), .SCRATCH_DEPTH(16), .DATA_W(16), .ACC_W(40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .filt_len_i  (filt_len_i),
        .num_out_i   (num_out_i),
        .if_wr_ptr_i (if_wr_ptr_i),
        .win_start_o (win_start_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic signed [15:0] in_mem   [16];
    logic signed [15:0] filt_mem [16];

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    int tb_ws    = 0;

    logic [7:0]  exp_rd_q  [$];
    logic [39:0] exp_out_q [$];
    logic [7:0]  exp_rd;
    logic [39:0] exp_out;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model_sum(input int w, input int n);
        longint s = 0;
        for (int k = 0; k < n; k++)
            s += longint'(in_mem[(w + k) % 16]) * longint'(filt_mem[k]);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        return 40'(s);
    endfunction

    // Scratchpad model: registered read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.if_data   <= in_mem[bus.if_rd_addr];
            bus.filt_data <= filt_mem[bus.filt_rd_addr];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                rd_cnt++;
                if (exp_rd_q.size() == 0) begin
                    check_val("rd_unexpected", bus.rd_en, 0);
                end else begin
                    exp_rd = exp_rd_q.pop_front();
                    check_val("rd_addr", {bus.if_rd_addr, bus.filt_rd_addr}, exp_rd);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (exp_out_q.size() == 0) begin
                    check_val("out_unexpected", bus.out_valid, 0);
                end else begin
                    exp_out = exp_out_q.pop_front();
                    check_val("out_data", $unsigned(bus.out_data), exp_out);
                end
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int n, input int nout);
        for (int j = 0; j < nout; j++) begin
            int w = (tb_ws + j) % 16;
            for (int k = 0; k < n; k++)
                exp_rd_q.push_back({4'((w + k) % 16), 4'(k)});
            exp_out_q.push_back(model_sum(w, n));
        end
        tb_ws = (tb_ws + nout) % 16;
    endtask

    task automatic start_run(input int n, input int nout, input int wr);
        if_wr_ptr_i = 4'(wr);
        filt_len_i  = 4'(n);
        num_out_i   = 8'(nout);
        push_run(n, nout);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!done_o && c < budget) begin
            tick();
            c++;
        end
        check_val(tag, done_o, 1);
        tick();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ws"},        win_start_o,       0);
        check_val({tag, "_rd_en"},     bus.rd_en,         0);
        check_val({tag, "_if_addr"},   bus.if_rd_addr,    0);
        check_val({tag, "_filt_addr"}, bus.filt_rd_addr,  0);
        check_val({tag, "_valid"},     bus.out_valid,     0);
        check_val({tag, "_data"},      $unsigned(bus.out_data), 0);
        check_val({tag, "_busy"},      busy_o,            0);
        check_val({tag, "_done"},      done_o,            0);
    endtask

    initial begin
        int c;
        int lat;
        int rd0, hs0, d0;
        logic stall_rd;
        logic held_ok;
        logic [39:0] exp2;

        rst = 1'b1;
        start_i = 1'b0;
        filt_len_i = '0;
        num_out_i = '0;
        if_wr_ptr_i = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_mem[i]   = 16'($urandom_range(0, 2000)) - 16'sd1000;
            filt_mem[i] = 16'($urandom_range(0, 200)) - 16'sd100;
        end
        in_mem[0] = 16'sd2;   in_mem[1] = -16'sd3;  in_mem[2] = 16'sd4;
        filt_mem[0] = 16'sd5; filt_mem[1] = 16'sd6; filt_mem[2] = -16'sd1;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Basic MAC: 2*5 - 3*6 - 4 = -12
        start_run(3, 1, 3);
        c = 0;
        while (!bus.rd_en && c < 20) begin tick(); c++; end
        check_val("basic_busy", busy_o, 1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin tick(); lat++; end
        check_val("basic_latency", lat, 4);
        wait_done("basic_done", 20);
        check_val("basic_ws", win_start_o, 1);
        check_val("basic_busy_end", busy_o, 0);

        // Data stall: only 2 of 4 samples present
        start_run(4, 1, 3);
        stall_rd = 1'b0;
        repeat (8) begin
            tick();
            if (bus.rd_en) stall_rd = 1'b1;
        end
        check_val("stall_no_read", stall_rd, 0);
        if_wr_ptr_i = 4'd5;
        tick();
        check_val("stall_resume", bus.rd_en, 1);
        wait_done("stall_done", 20);
        check_val("stall_ws", win_start_o, 2);

        // N=0 outputs: zero results, no reads; also moves window to 14
        rd0 = rd_cnt;
        hs0 = hs_cnt;
        start_run(0, 12, 2);
        wait_done("n0_done", 100);
        check_val("n0_no_read", rd_cnt - rd0, 0);
        check_val("n0_handshakes", hs_cnt - hs0, 12);
        check_val("n0_ws", win_start_o, 14);

        // Wrap-around reads 14,15,0,1
        start_run(4, 1, 3);
        wait_done("wrap_done", 30);
        check_val("wrap_ws", win_start_o, 15);

        // Backpressure on output 2 of 3
        hs0 = hs_cnt;
        d0 = done_cnt;
        exp2 = model_sum(0, 2);
        start_run(2, 3, 3);
        c = 0;
        while (hs_cnt < hs0 + 1 && c < 50) begin tick(); c++; end
        bus.out_ready = 1'b0;
        c = 0;
        while (!bus.out_valid && c < 50) begin tick(); c++; end
        held_ok = 1'b1;
        repeat (5) begin
            if (!bus.out_valid || bus.out_data !== exp2) held_ok = 1'b0;
            tick();
        end
        check_val("bp_hold", held_ok, 1);
        bus.out_ready = 1'b1;
        wait_done("bp_done", 50);
        check_val("bp_handshakes", hs_cnt - hs0, 3);
        check_val("bp_done_pulses", done_cnt - d0, 1);
        check_val("bp_ws", win_start_o, 2);

        // num_out=0: done two cycles after start, no output
        hs0 = hs_cnt;
        start_run(3, 0, 0);
        check_val("nout0_busy", busy_o, 1);
        check_val("nout0_done_early", done_o, 0);
        tick();
        check_val("nout0_done", done_o, 1);
        check_val("nout0_busy_end", busy_o, 0);
        tick();
        check_val("nout0_no_out", hs_cnt - hs0, 0);
        check_val("nout0_ws", win_start_o, 2);

        // start while busy must not reload N / num_out
        hs0 = hs_cnt;
        start_run(3, 2, 8);
        tick();
        tick();
        filt_len_i = 4'd7;
        num_out_i = 8'd9;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done("busy_start_done", 100);
        check_val("busy_start_hs", hs_cnt - hs0, 2);
        check_val("busy_start_rdq", exp_rd_q.size(), 0);
        check_val("busy_start_outq", exp_out_q.size(), 0);
        check_val("busy_start_ws", win_start_o, 4);

        // Reset during READ
        start_run(5, 1, 12);
        c = 0;
        while (!bus.rd_en && c < 20) begin tick(); c++; end
        tick();
        check_val("pre_rst_read", bus.rd_en, 1);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        exp_rd_q.delete();
        exp_out_q.delete();
        tb_ws = 0;
        tick();
        rst = 1'b0;
        tick();

        // Fresh accumulation after reset
        start_run(3, 1, 3);
        wait_done("post_rst_done", 30);
        check_val("post_rst_ws", win_start_o, 1);
        check_val("post_rst_outq", exp_out_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Sequences one signed multiply-accumulate datapath over a circular input scratchpad and a linear filter scratchpad.
- Per output: waits until enough input samples are present, then reads filt_len samples and weights and accumulates their products. It presents the sum on a valid/ready output, then slides the window by one sample.
- Sits between the input scratchpad (producer advances if_wr_ptr) and the downstream output buffer.

Parameters:
- ADDR_LEN, 4, scratchpad address width.
- SCRATCH_DEPTH, 16, circular input scratchpad entries. Must be ≤ 2^ADDR_LEN and ≥ 2.
- DATA_W, 16, signed width of input samples and filter weights.
- ACC_W, 40, signed accumulator/output width. Must be ≥ 2*DATA_W + ADDR_LEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches filt_len and num_out. Ignored unless busy=0.
- filt_len  in  ADDR_LEN  filter taps N, 0..SCRATCH_DEPTH-1.
- num_out  in  8  outputs to produce this run.
- if_wr_ptr  in  ADDR_LEN  producer write pointer; the next slot it will write.
- if_rd_addr  out  ADDR_LEN  input scratchpad read address.
- filt_rd_addr  out  ADDR_LEN  filter scratchpad read address.
- rd_en  out  1  read strobe to both scratchpads. Read data is valid one cycle later.
- if_data  in  DATA_W  signed input sample.
- filt_data  in  DATA_W  signed filter weight.
- win_start  out  ADDR_LEN  current window start pointer, which the producer uses as its read/free pointer.
- out_data  out  ACC_W  signed result.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accept.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output is accepted.

Behaviour:
- Reset: state IDLE. All of the following are 0: win_start, if_rd_addr, filt_rd_addr, rd_en, out_data, out_valid, busy, done, the accumulator and all counters.
- Available count = if_wr_ptr − win_start modulo SCRATCH_DEPTH; equal pointers means empty. The producer never fills more than SCRATCH_DEPTH−1 entries.
- IDLE:
  - start → latch N and num_out; busy=1.
  - num_out=0: go to FINISH.
  - otherwise: go to WAIT.
- WAIT:
  - available ≥ N → READ, with accumulator cleared and tap index k=0.
  - N=0 → OUT directly with out_data=0; no reads occur.
- READ: lasts exactly N cycles, k=0..N−1.
  - rd_en=1.
  - if_rd_addr = (win_start + k) mod SCRATCH_DEPTH; wraps from SCRATCH_DEPTH−1 to 0.
  - filt_rd_addr = k.
  - In cycle k≥1: acc += if_data*filt_data. This is the full-precision signed product of the tap k−1 data, sign-extended to ACC_W.
- DRAIN: one cycle; rd_en=0; accumulates tap N−1. Next state OUT.
- OUT: out_valid=1 and out_data stable until out_ready.
  - Result for N≥1: out_valid first rises N+1 cycles after the READ k=0 cycle.
  - On the handshake cycle, out_valid falls next cycle, win_start advances by 1 (with wrap) and the output counter increments.
  - Counter reaches num_out → FINISH; otherwise → WAIT.
- FINISH: done=1 for one cycle, busy=0, → IDLE. win_start is retained across runs and is not reset by start.
- start while busy=1: ignored.
- Mid-operation changes:
  - if_wr_ptr changes during READ/DRAIN/OUT do not affect the current window.
  - Asynchronous rst in any state returns to reset values immediately; a partial accumulation is discarded.
- No arithmetic overflow is possible under the ACC_W constraint; wrapping two's complement otherwise.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: in OUT, out_data = 0 when the accumulated sum is negative, otherwise the sum. Handshake and latency are unchanged.
- Undefined: out_data is the raw signed sum.

Test Plan:
- Basic MAC:
  - Stimulus: win_start=0, if_wr_ptr=3, input samples 2,−3,4, weights 5,6,−1, N=3, num_out=1.
  - Response: reads at addresses 0,1,2; out_valid 4 cycles after first rd_en; out_data=−12 (0 with CONV_RELU_EN); win_start→1; done pulse.
- Data stall:
  - Stimulus: N=4 with only 2 samples available.
  - Response: stays in WAIT, rd_en=0. When if_wr_ptr advances by 2, READ begins the next cycle.
- Wrap-around:
  - Stimulus: win_start=14, SCRATCH_DEPTH=16, N=4.
  - Response: if_rd_addr sequence 14,15,0,1; filt_rd_addr 0,1,2,3.
- Backpressure and multi-output:
  - Stimulus: num_out=3, out_ready low for 5 cycles on output 2.
  - Response: out_data is held stable; exactly 3 handshakes; win_start advances by 3; single done pulse.
- Edge inputs:
  - Stimulus: first num_out=0, then N=0.
  - Response: num_out=0 gives done 2 cycles after start with no out_valid. N=0 gives out_data=0 with no rd_en.
- Reset and start handling:
  - Stimulus: rst asserted during READ; start asserted while busy.
  - Response: rst returns all outputs to 0. The start-while-busy pulse does not alter latched N or num_out.
